// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear registers and a shared
// free-running blink timer that gates selected channels at a programmable half-period.
module led_pio_blink #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned DATA_RESET   = 0,
    parameter int unsigned PERIOD_RESET = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_en_q, blink_en_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    // Upper writedata bits are intentionally discarded.
    assign unused_wdata = ^writedata;

    // Register writes, blink timer and output gating.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        out_d      = data_q & (~blink_en_q | {WIDTH{phase_q}});

        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = wr_bits;
                ADDR_BLINK_EN: blink_en_d = wr_bits;
                ADDR_PERIOD:   period_d   = writedata[CNT_W-1:0];
                ADDR_OUTSET:   data_d     = data_q | wr_bits;
                ADDR_OUTCLR:   data_d     = data_q & ~wr_bits;
                default:       ;
            endcase
        end

        // A PERIOD write restarts the timer and beats any terminal-count toggle.
        if (wr_en && (address == ADDR_PERIOD)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == (period_q - CNT_W'(1))) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= WIDTH'(DATA_RESET);
            blink_en_q <= '0;
            period_q   <= CNT_W'(PERIOD_RESET);
            cnt_q      <= '0;
            phase_q    <= 1'b1;
            out_q      <= WIDTH'(DATA_RESET);
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
        end
    end

    assign out_port = out_q;

    // Zero-latency read mux; decoded from address alone.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_STATUS:   readdata = {31'd0, phase_q};
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pio_blink.sv
// Self-checking bench for led_pio_blink: constant vector table, hand-written
// blink/boundary/reset sequences and random traffic against a behavioural model.
module tb_led_pio_blink;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_cmp;
    int n_fail;

    led_pio_blink #(
        .WIDTH       (4),
        .CNT_W       (8),
        .DATA_RESET  (5),
        .PERIOD_RESET(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase derived arithmetically from edges since the last timer restart.
    logic [3:0]  m_data;
    logic [3:0]  m_en;
    logic [3:0]  m_out;
    int unsigned m_period;
    int unsigned m_k;

    function automatic logic m_phase();
        if (m_period == 0) return 1'b1;
        return ((m_k / m_period) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_data   = 4'h5;
        m_en     = 4'h0;
        m_period = 4;
        m_k      = 0;
        m_out    = 4'h5;
    endtask

    task automatic model_edge(input logic wr, input logic [2:0] a, input logic [31:0] wd);
        logic [3:0] lo;
        lo    = wd[3:0];
        m_out = m_data & (~m_en | {4{m_phase()}});
        m_k++;
        if (wr) begin
            case (a)
                3'd0: m_data = lo;
                3'd1: m_en   = lo;
                3'd2: begin m_period = 32'(wd[7:0]); m_k = 0; end
                3'd4: m_data = m_data | lo;
                3'd5: m_data = m_data & ~lo;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, m_data};
            3'd1:    return {28'd0, m_en};
            3'd2:    return m_period;
            3'd3:    return {31'd0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare against the model.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_edge(cs & ~wn, a, wd);
        @(negedge clk);
        check("model_out", 32'(out_port), 32'(m_out));
        check("model_rd", readdata, exp_rd(a));
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t        vt[10];
    logic [31:0] rst_rd[4];
    logic [3:0]  bseq[9];

    initial begin
        logic found;
        n_cmp      = 0;
        n_fail     = 0;
        clk        = 1'b0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;

        rst_rd = '{32'd5, 32'd0, 32'd4, 32'd1};
        bseq   = '{4'hF, 4'hF, 4'hF, 4'h9, 4'h9, 4'h9, 4'hF, 4'hF, 4'hF};
        vt[0]  = '{1'b1, 3'd0, 32'hFFFF_FFF3, 3'd0, 32'h3, 4'h3};
        vt[1]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 3'd0, 32'h3, 4'h3};
        vt[2]  = '{1'b0, 3'd0, 32'h0,         3'd4, 32'h0, 4'h3};
        vt[3]  = '{1'b1, 3'd4, 32'hFFFF_FFF8, 3'd0, 32'hB, 4'hB};
        vt[4]  = '{1'b1, 3'd5, 32'h0000_0001, 3'd0, 32'hA, 4'hA};
        vt[5]  = '{1'b0, 3'd0, 32'h0,         3'd1, 32'h0, 4'hA};
        vt[6]  = '{1'b1, 3'd2, 32'h0000_0100, 3'd2, 32'h0, 4'hA};
        vt[7]  = '{1'b0, 3'd0, 32'h0,         3'd3, 32'h1, 4'hA};
        vt[8]  = '{1'b1, 3'd1, 32'hFFFF_FFF6, 3'd1, 32'h6, 4'hA};
        vt[9]  = '{1'b1, 3'd5, 32'h0000_000F, 3'd0, 32'h0, 4'h0};

        // Reset values are visible while reset is held.
        #3;
        check("rst_out", 32'(out_port), 32'h5);
        for (int a = 0; a < 4; a++) begin
            address = 3'(a);
            #1;
            check("rst_rd", readdata, rst_rd[a]);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        address = 3'd0;
        #1;
        check("rel_out", 32'(out_port), 32'h5);
        check("rel_rd", readdata, 32'h5);

        for (int i = 0; i < 10; i++) begin
            step(vt[i].wr, ~vt[i].wr, vt[i].waddr, vt[i].wdata);
            step(1'b0, 1'b1, vt[i].raddr, 32'd0);
            check("tbl_rd", readdata, vt[i].exp_rd);
            check("tbl_out", 32'(out_port), 32'(vt[i].exp_out));
        end

        // Blink with half-period 3 on channels 1 and 2.
        step(1'b1, 1'b0, 3'd0, 32'hF);
        step(1'b1, 1'b0, 3'd1, 32'h6);
        step(1'b1, 1'b0, 3'd2, 32'h3);
        for (int j = 1; j <= 9; j++) begin
            step(1'b0, 1'b1, 3'd3, 32'd0);
            check("blink_out", 32'(out_port), 32'(bseq[j-1]));
            check("blink_phase", readdata, ((j / 3) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // PERIOD=0 freezes the timer with phase high.
        step(1'b1, 1'b0, 3'd2, 32'h0);
        for (int j = 1; j <= 6; j++) begin
            step(1'b0, 1'b1, 3'd3, 32'd0);
            check("p0_phase", readdata, 32'd1);
            check("p0_out", 32'(out_port), 32'hF);
        end

        // PERIOD=1 toggles every clock.
        step(1'b1, 1'b0, 3'd2, 32'h1);
        for (int j = 1; j <= 6; j++) begin
            step(1'b0, 1'b1, 3'd3, 32'd0);
            check("p1_phase", readdata, (j % 2 == 0) ? 32'd1 : 32'd0);
            check("p1_out", 32'(out_port), (j % 2 == 1) ? 32'hF : 32'h9);
        end

        // PERIOD write landing on the terminal-count edge suppresses the toggle.
        step(1'b1, 1'b0, 3'd2, 32'h3);
        step(1'b0, 1'b1, 3'd3, 32'd0);
        step(1'b0, 1'b1, 3'd3, 32'd0);
        step(1'b1, 1'b0, 3'd2, 32'h3);
        address = 3'd3;
        #1;
        check("tc_phase", readdata, 32'd1);
        for (int j = 1; j <= 3; j++) begin
            step(1'b0, 1'b1, 3'd3, 32'd0);
            check("tc_after", readdata, (j < 3) ? 32'd1 : 32'd0);
        end

        // Reset asserted mid-blink while phase is low.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b1, 3'd3, 32'd0);
            if (readdata[0] == 1'b0) found = 1'b1;
        end
        check("find_phase0", {31'd0, found}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(out_port), 32'h5);
        check("mid_rst_status", readdata, 32'd1);
        address = 3'd2;
        #1;
        check("mid_rst_period", readdata, 32'd4);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 1'b1, 3'd3, 32'd0);
            check("post_rst_phase", readdata, ((j / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Random traffic against the model; PERIOD kept small so blinking is exercised.
        for (int i = 0; i < 400; i++) begin
            logic        cs;
            logic        wn;
            logic [2:0]  a;
            logic [31:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            wn = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd = (wd & 32'hFFFF_FF00) | 32'($urandom_range(0, 6));
            step(cs, wn, a, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pio_blink.md
# led_pio_blink

Parametrised Avalon-MM LED output port that supersedes the fixed 4-bit LED PIO. It is a memory-mapped slave on the HPS/Qsys lightweight bus, driving up to 32 board LEDs. Beyond plain data writes, it adds atomic per-bit set/clear registers and a shared free-running blink timer that gates selected channels at a programmable half-period.

## Interface
Parameters:
- WIDTH, 4: number of output channels; legal range 1–32.
- CNT_W, 26: width of the blink period register and counter; legal range 2–32.
- DATA_RESET, 0: reset value of DATA, using WIDTH bits.
- PERIOD_RESET, 25000000: reset value of PERIOD in clocks; must fit in CNT_W bits.

Ports:
- clk, in, 1: single clock domain for all logic.
- reset, in, 1: asynchronous, active-high reset.
- address, in, 3: word address.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata, in, 32: write data.
- readdata, out, 32: read data with zero read latency (combinational from registers).
- out_port, out, WIDTH: registered LED drive.

## Operation
Register map (word address):
- 0 DATA, RW: write sets DATA to writedata[WIDTH-1:0].
- 1 BLINK_EN, RW: bit i=1 enables blinking on channel i.
- 2 PERIOD, RW: blink half-period in clocks. A write also clears cnt to 0 and sets phase to 1.
- 3 STATUS, RO: bit0 = phase; all other bits 0. Writes are ignored.
- 4 OUTSET, WO: DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
- 5 OUTCLR, WO: DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
- 6, 7: reserved. Reads return 0; writes are ignored.

Width rules:
- writedata bits at or above WIDTH (CNT_W for PERIOD) are discarded.
- readdata is zero-extended to 32 bits.
- readdata is independent of chipselect; the address decode alone selects the register.

Blink timer:
- When PERIOD≠0, cnt increments every clock. When cnt = PERIOD−1, cnt goes to 0 and phase toggles on the same edge.
- PERIOD=1 toggles phase every clock.
- PERIOD=0 stops the timer: cnt holds at 0 and phase holds at 1, so enabled channels show steady DATA.
- A PERIOD write coinciding with terminal count: the write wins (cnt=0, phase=1).
- Writes to DATA, BLINK_EN, OUTSET and OUTCLR never disturb cnt or phase.

Output function, per channel:
- out_port[i] <= DATA[i] & (~BLINK_EN[i] | phase).
- A channel with DATA[i]=0 stays dark regardless of blink.

## Timing
Reset values:
- DATA=DATA_RESET, BLINK_EN=0, PERIOD=PERIOD_RESET, cnt=0, phase=1.
- out_port=DATA_RESET; it is reset directly, not one cycle later.

Latency:
- A register write takes effect at the clock edge that samples it (edge N).
- out_port reflects the write at edge N+1.
- A phase toggle at edge N appears on out_port at edge N+1.

Other rules:
- readdata reflects a write in the cycle after edge N; there are no wait states.
- Assertion of reset at any time, including mid-blink or during a write, immediately forces all reset values. The first write is accepted at the first rising edge after deassertion.
- Only one write per cycle is possible, so there are no set/clear/data write conflicts.

## Test plan
Bench configuration: WIDTH=4, CNT_W=8, DATA_RESET=4'h5, PERIOD_RESET=4.

1. Reset then read: reads at addresses 0/1/2/3 return 5/0/4/1; out_port=4'h5 during reset and after release.
2. Write DATA=0xFFFF_FFF3: read 0 returns 0x3; out_port=4'h3 one edge after the write; a write to address 6 and a read of address 4 return 0 with DATA unchanged.
3. Atomics: from DATA=0x3, OUTSET 0x8 gives DATA=0xB; OUTCLR 0x1 gives DATA=0xA; BLINK_EN remains 0.
4. Blink: DATA=0xF, BLINK_EN=0x6, PERIOD=3. After the PERIOD write, phase toggles every 3 clocks; out_port alternates 4'hF and 4'h9 with 3-cycle dwell, each lagging phase by 1 cycle.
5. Boundaries:
   - PERIOD=0 freezes phase=1 and out_port=4'hF.
   - PERIOD=1 toggles every clock.
   - A PERIOD write on the terminal-count cycle yields cnt=0 and phase=1 with no toggle.
6. Reset mid-operation: assert reset while blinking with phase=0; out_port=4'h5 and STATUS=1 immediately. After release, the timer runs with PERIOD=4.
